// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory line arbiter:
// FSM states, owner encoding and burst-length constants.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int WORDS_PER_LINE = 4;
    localparam logic [2:0] CNT_MAX = 3'(WORDS_PER_LINE);

    // Burst counters stop at one line's worth so a stray extra return cannot wrap them.
    function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/mem_line_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_valid,
    output logic       o_owner
);

    always_comb begin
        o_valid = |i_req;
        o_owner = OWN_I;
        if (i_req == 2'b11) begin
            o_owner = ~i_last_owner;
        end else if (i_req[OWN_D]) begin
            o_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Arbitrates I-cache and D-cache line bursts onto the shared banked memory,
// generating word addresses and routing in-order read returns to the owner.
module mem_line_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_gnt,
    output logic              d_gnt,
    output logic              i_done,
    output logic              d_done,
    output logic              i_rvalid,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rword,
    output logic [1:0]        word_idx,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state, w_state_next;
    logic              r_owner, w_owner_next;
    logic              r_wr, w_wr_next;
    logic              r_last_owner, w_last_owner_next;
    logic [ADDR_W-4:0] r_line, w_line_next;
    logic [2:0]        r_issue_cnt, w_issue_cnt_next;
    logic [2:0]        r_ret_cnt, w_ret_cnt_next;

    logic       w_pick_valid;
    logic       w_pick_owner;
    logic       w_in_burst;
    logic       w_ret_fire;
    logic       w_accept;
    logic [2:0] w_ret_cnt_inc;

    // Line offset bits and the nominal latency do not steer any logic.
    logic w_unused;
    assign w_unused = &{1'b0, i_addr[2:0], d_addr[2:0], MEM_LAT > 0};

    rr_arb2 u_rr_arb2 (
        .i_req        ({d_req, i_req}),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_owner      (w_pick_owner)
    );

    assign w_in_burst    = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_ret_fire    = w_in_burst & ~r_wr & mem_rvalid;
    assign w_accept      = (r_state == ISSUE) & ~mem_stall;
    assign w_ret_cnt_inc = w_ret_fire ? sat_inc(r_ret_cnt) : r_ret_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_I;
            r_wr         <= 1'b0;
            r_last_owner <= OWN_D;
            r_line       <= '0;
            r_issue_cnt  <= 3'd0;
            r_ret_cnt    <= 3'd0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_wr         <= w_wr_next;
            r_last_owner <= w_last_owner_next;
            r_line       <= w_line_next;
            r_issue_cnt  <= w_issue_cnt_next;
            r_ret_cnt    <= w_ret_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_wr_next         = r_wr;
        w_last_owner_next = r_last_owner;
        w_line_next       = r_line;
        w_issue_cnt_next  = r_issue_cnt;
        w_ret_cnt_next    = r_ret_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_owner_next     = w_pick_owner;
                    w_wr_next        = (w_pick_owner == OWN_D) ? d_wr : 1'b0;
                    w_line_next      = (w_pick_owner == OWN_D) ? d_addr[ADDR_W-1:3]
                                                               : i_addr[ADDR_W-1:3];
                    w_issue_cnt_next = 3'd0;
                    w_ret_cnt_next   = 3'd0;
                    w_state_next     = ISSUE;
                end
            end
            ISSUE: begin
                w_ret_cnt_next = w_ret_cnt_inc;
                if (w_accept) begin
                    w_issue_cnt_next = sat_inc(r_issue_cnt);
                    // Last word accepted: reads wait for their returns unless already complete.
                    if (r_issue_cnt == 3'(WORDS_PER_LINE - 1)) begin
                        if (r_wr || (w_ret_cnt_inc == CNT_MAX)) begin
                            w_state_next = DONE;
                        end else begin
                            w_state_next = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                w_ret_cnt_next = w_ret_cnt_inc;
                if (w_ret_cnt_inc == CNT_MAX) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_last_owner_next = r_owner;
                w_state_next      = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign i_gnt     = busy & (r_owner == OWN_I);
    assign d_gnt     = busy & (r_owner == OWN_D);
    assign i_done    = (r_state == DONE) & (r_owner == OWN_I);
    assign d_done    = (r_state == DONE) & (r_owner == OWN_D);
    assign mem_req   = (r_state == ISSUE);
    assign mem_wr    = mem_req & r_wr;
    assign word_idx  = mem_req ? r_issue_cnt[1:0] : 2'b00;
    assign mem_addr  = {r_line, word_idx, 1'b0};
    assign mem_wdata = d_wdata;
    assign i_rvalid  = w_ret_fire & (r_owner == OWN_I);
    assign d_rvalid  = w_ret_fire & (r_owner == OWN_D);
    assign rdata     = w_ret_fire ? mem_rdata : '0;
    assign rword     = w_ret_fire ? r_ret_cnt[1:0] : 2'b00;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: vector table of line bursts plus
// hand sequences for round-robin ties, stalls, stray returns and mid-burst reset.
module tb_mem_line_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        i_gnt, d_gnt, i_done, d_done, i_rvalid, d_rvalid;
    logic [15:0] rdata;
    logic [1:0]  rword;
    logic [1:0]  word_idx;
    logic        busy, mem_req, mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_stall;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    mem_line_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .i_done(i_done), .d_done(d_done),
        .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .rdata(rdata), .rword(rword),
        .word_idx(word_idx), .busy(busy),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // D-cache supplies the write word for whatever index is on the bus.
    assign d_wdata = 16'hD000 + {14'd0, word_idx};

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic [1:0]  word;
    } iss_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  word;
        logic        own;
    } ret_t;

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        dwr;
        logic [15:0] iaddr;
        logic [15:0] daddr;
        int          lat;
        logic        own;
        int          cycles;
    } vec_t;

    iss_t exp_iss[$];
    ret_t exp_ret[$];

    logic        ret_v[16];
    logic [15:0] ret_d[16];
    int cyc;
    int lat_cfg;
    int stall_budget;
    logic spur_on;
    int acc_cnt;
    int w1_cycles;
    int n_chk;
    int n_fail;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        iss_t e;
        ret_t r;
        ret_v[cyc % 16] = 1'b0;
        if (mem_req) begin
            if (exp_iss.size() == 0) begin
                chk("issue_expected", {31'd0, mem_req}, 32'd0);
            end else begin
                e = exp_iss[0];
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                chk("word_idx", {30'd0, word_idx}, {30'd0, e.word});
                chk("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
                if (e.wr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
                if (!mem_stall) begin
                    void'(exp_iss.pop_front());
                    acc_cnt++;
                    if (!mem_wr) begin
                        ret_v[(cyc + lat_cfg) % 16] = 1'b1;
                        ret_d[(cyc + lat_cfg) % 16] = mem_model(mem_addr);
                    end
                end
            end
            if (word_idx == 2'd1) w1_cycles++;
        end
        if (mem_rvalid || i_rvalid || d_rvalid) begin
            if (exp_ret.size() == 0) begin
                chk("no_stray_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
            end else begin
                r = exp_ret.pop_front();
                chk("rvalid_owner", {30'd0, i_rvalid, d_rvalid}, r.own ? 32'd1 : 32'd2);
                chk("rdata", {16'd0, rdata}, {16'd0, r.data});
                chk("rword", {30'd0, rword}, {30'd0, r.word});
            end
        end
    endtask

    // One clock: memory model drives just after the edge, checks run on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mem_rvalid = ret_v[cyc % 16] | spur_on;
        mem_rdata  = ret_v[cyc % 16] ? ret_d[cyc % 16] : 16'hBAD0;
        if (mem_req && word_idx == 2'd1 && stall_budget > 0) begin
            mem_stall = 1'b1;
            stall_budget--;
        end else begin
            mem_stall = 1'b0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic push_exp(input logic [15:0] addr, input logic own, input logic wr);
        iss_t e;
        ret_t r;
        logic [15:0] line;
        line = addr & 16'hFFF8;
        for (int w = 0; w < 4; w++) begin
            e.addr  = line | 16'(w << 1);
            e.wr    = own & wr;
            e.wdata = 16'hD000 + 16'(w);
            e.word  = 2'(w);
            exp_iss.push_back(e);
            if (!(own & wr)) begin
                r.data = mem_model(e.addr);
                r.word = 2'(w);
                r.own  = own;
                exp_ret.push_back(r);
            end
        end
    endtask

    task automatic run_burst(input logic ir, input logic dr, input logic dw,
                             input logic [15:0] ia, input logic [15:0] da,
                             input int lat, input logic own, input int cycles);
        int k;
        int bad;
        lat_cfg = lat;
        i_addr  = ia;
        d_addr  = da;
        d_wr    = dw;
        i_req   = ir;
        d_req   = dr;
        push_exp(own ? da : ia, own, dw);
        tick();
        k = 1;
        while (!(i_gnt || d_gnt) && k < 8) begin
            tick();
            k++;
        end
        chk("gnt_latency", k, 1);
        chk("gnt_owner", {30'd0, i_gnt, d_gnt}, own ? 32'd1 : 32'd2);
        bad = 0;
        k = 0;
        while (!(i_done || d_done) && k < 40) begin
            if (own ? i_gnt : d_gnt) bad++;
            tick();
            k++;
        end
        chk("done_cycle", k, cycles);
        chk("done_owner", {30'd0, i_done, d_done}, own ? 32'd1 : 32'd2);
        chk("gnt_at_done", {30'd0, i_gnt, d_gnt}, own ? 32'd1 : 32'd2);
        chk("other_gnt_low", bad, 0);
    endtask

    task automatic end_burst(input logic ir, input logic dr);
        i_req = ir;
        d_req = dr;
        tick();
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        chk("sb_drained", exp_iss.size() + exp_ret.size(), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_gnt"}, {30'd0, i_gnt, d_gnt}, 32'd0);
        chk({tag, "_memreq"}, {30'd0, mem_req, mem_wr}, 32'd0);
        chk({tag, "_word_idx"}, {30'd0, word_idx}, 32'd0);
        chk({tag, "_done"}, {30'd0, i_done, d_done}, 32'd0);
        chk({tag, "_rvalid"}, {30'd0, i_rvalid, d_rvalid}, 32'd0);
    endtask

    vec_t vecs[5];
    int n;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; lat_cfg = 2; stall_budget = 0;
        spur_on = 1'b0; acc_cnt = 0; w1_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            ret_v[i] = 1'b0;
            ret_d[i] = 16'd0;
        end
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'd0; d_addr = 16'd0;
        mem_stall = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'd0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 2, 1'b0, 6};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2008, 3, 1'b1, 7};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h200F, 5, 1'b1, 9};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0ABC, 1, 1'b1, 4};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 1, 1'b0, 5};

        tick();
        tick();
        chk_quiet("reset");
        chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_rword", {30'd0, rword}, 32'd0);
        chk("reset_rdata", {16'd0, rdata}, 32'd0);
        rst = 1'b0;
        tick();

        // First tie after reset goes to I, D follows while still requesting, a repeat tie goes to I.
        run_burst(1'b1, 1'b1, 1'b0, 16'h3002, 16'h4008, 2, 1'b0, 6);
        end_burst(1'b0, 1'b1);
        run_burst(1'b0, 1'b1, 1'b0, 16'h3002, 16'h4008, 2, 1'b1, 6);
        end_burst(1'b1, 1'b1);
        run_burst(1'b1, 1'b1, 1'b0, 16'h3002, 16'h4008, 2, 1'b0, 6);
        end_burst(1'b0, 1'b0);

        for (int v = 0; v < 5; v++) begin
            run_burst(vecs[v].ireq, vecs[v].dreq, vecs[v].dwr, vecs[v].iaddr,
                      vecs[v].daddr, vecs[v].lat, vecs[v].own, vecs[v].cycles);
            end_burst(1'b0, 1'b0);
        end

        // Writeback with word 1 stalled for two cycles.
        stall_budget = 2;
        w1_cycles = 0;
        run_burst(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0040, 1, 1'b1, 6);
        chk("word1_hold", w1_cycles, 3);
        end_burst(1'b0, 1'b0);

        // Stray returns during a writeback and while idle.
        spur_on = 1'b1;
        run_burst(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0100, 1, 1'b1, 4);
        end_burst(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_spur_busy", {31'd0, busy}, 32'd0);
        end
        spur_on = 1'b0;

        // Reset after two words of an I read; late returns land after release.
        lat_cfg = 4;
        i_addr = 16'h5550;
        i_req = 1'b1;
        push_exp(16'h5550, 1'b0, 1'b0);
        acc_cnt = 0;
        n = 0;
        while (acc_cnt < 2 && n < 10) begin
            tick();
            n++;
        end
        chk("words_before_rst", acc_cnt, 2);
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        chk("midrst_mem_addr", {16'd0, mem_addr}, 32'd0);
        exp_iss.delete();
        exp_ret.delete();
        i_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_idle", {31'd0, busy}, 32'd0);
        end
        run_burst(1'b0, 1'b1, 1'b0, 16'h0000, 16'h6008, 2, 1'b1, 6);
        end_burst(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
